// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder and its load extender.
package rv_mem_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      MEM_B   = 2'b00,
      MEM_H   = 2'b01,
      MEM_W   = 2'b10,
      MEM_BAD = 2'b11
   } mem_size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } dmem_state_e;

   typedef struct packed {
      logic            write;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
      mem_size_e       size;
      logic            uns;
   } dmem_req_t;

   // Byte-lane enable for a store of the given size at the given word offset.
   function automatic logic [3:0] lane_mask(mem_size_e size, logic [1:0] addr_lo);
      logic [3:0] m;
      case (size)
         MEM_B:   m = 4'b0001 << addr_lo;
         MEM_H:   m = addr_lo[1] ? 4'b1100 : 4'b0011;
         MEM_W:   m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake between the MEM stage (master) and the data memory (slave).
interface dmem_if;
   import rv_mem_pkg::*;

   logic            req_valid;
   logic            req_ready;
   logic            req_write;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] req_wdata;
   logic [1:0]      req_size;
   logic            req_unsigned;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [XLEN-1:0] rsp_rdata;
   logic            rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder_load_ext.sv
// Picks the addressed byte/half out of a memory word and sign- or zero-extends it.
module dmem_load_ext
   import rv_mem_pkg::*;
(
   input  logic [XLEN-1:0] word,
   input  logic [1:0]      addr_lo,
   input  mem_size_e       size,
   input  logic            uns,
   output logic [XLEN-1:0] result_c
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane selection and extension
   always_comb begin
      case (addr_lo)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      half_sel = addr_lo[1] ? word[31:16] : word[15:0];
      case (size)
         MEM_B:   result_c = uns ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         MEM_H:   result_c = uns ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: result_c = word;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target: one outstanding load/store with configurable wait states.
module dmem_responder
   import rv_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input logic   clk,
   input logic   reset_n,
   dmem_if.slave bus
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W = 4;

   dmem_state_e      state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   dmem_req_t        live, cap, cur;
   logic             accept, do_access, err;
   logic [IDX_W-1:0] idx;
   logic [3:0]       mask;
   logic [XLEN-1:0]  lane_data, rd_word, ext;
   logic [XLEN-1:0]  mem [DEPTH_WORDS];
   logic             ready_q, valid_q, err_q;
   logic [XLEN-1:0]  rdata_q;

   assign live = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata,
                   size: mem_size_e'(bus.req_size), uns: bus.req_unsigned};
   assign accept = (state == ST_IDLE) && bus.req_valid;

   // With zero wait states the access happens on the acceptance edge, so it must see the live bus
   assign cur = (state == ST_IDLE) ? live : cap;

   assign err = (cur.size == MEM_BAD)
             || ((cur.size == MEM_H) && cur.addr[0])
             || ((cur.size == MEM_W) && (cur.addr[1:0] != 2'b00))
             || (cur.addr[31:2] >= 30'(DEPTH_WORDS));

   assign idx     = cur.addr[IDX_W+1:2];
   assign mask    = lane_mask(cur.size, cur.addr[1:0]);
   assign rd_word = mem[idx];

   // Replicate store data so every enabled lane sees its own bytes
   always_comb begin
      case (cur.size)
         MEM_B:   lane_data = {4{cur.wdata[7:0]}};
         MEM_H:   lane_data = {2{cur.wdata[15:0]}};
         default: lane_data = cur.wdata;
      endcase
   end

   dmem_load_ext u_load_ext (
      .word     (rd_word),
      .addr_lo  (cur.addr[1:0]),
      .size     (cur.size),
      .uns      (cur.uns),
      .result_c (ext)
   );

   // Next-state and wait-counter logic
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      do_access = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.req_valid) begin
               if (WAIT_CYCLES == 0) begin
                  state_n   = ST_RESP;
                  do_access = 1'b1;
               end else begin
                  state_n = ST_WAIT;
                  cnt_n   = CNT_W'(WAIT_CYCLES - 1);
               end
            end
         end
         ST_WAIT: begin
            if (cnt == '0) begin
               state_n   = ST_RESP;
               do_access = 1'b1;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // State and wait counter registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // Request capture at acceptance; later bus changes are ignored
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cap <= '0;
      else if (accept) cap <= live;
   end

   // Memory array: word i holds i after reset, lane-masked store once per transaction
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem[i] <= XLEN'(i);
      end else if (do_access && !err && cur.write) begin
         for (int l = 0; l < 4; l++) begin
            if (mask[l]) mem[idx][8*l +: 8] <= lane_data[8*l +: 8];
         end
      end
   end

   // Registered handshake outputs and response payload
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         ready_q <= (state_n == ST_IDLE);
         valid_q <= (state_n == ST_RESP);
         if (do_access) begin
            rdata_q <= (err || cur.write) ? '0 : ext;
            err_q   <= err;
         end
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.rsp_valid = valid_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed and random transactions checked against a word-array model.
module tb_dmem_responder;

   localparam int unsigned DEPTH = 256;

   logic clk = 1'b0;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;

   logic [31:0] model1 [DEPTH];
   logic [31:0] model0 [DEPTH];

   dmem_if bus1 ();
   dmem_if bus0 ();

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) u_dut1 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus1)
   );

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus0)
   );

   always #5 clk = ~clk;

   function automatic logic get_rv(input bit w);
      return w ? bus1.rsp_valid : bus0.rsp_valid;
   endfunction

   function automatic logic get_rq(input bit w);
      return w ? bus1.req_ready : bus0.req_ready;
   endfunction

   function automatic logic [31:0] get_rd(input bit w);
      return w ? bus1.rsp_rdata : bus0.rsp_rdata;
   endfunction

   function automatic logic get_er(input bit w);
      return w ? bus1.rsp_err : bus0.rsp_err;
   endfunction

   task automatic set_req(input bit w, input bit v, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size, input bit uns);
      if (w) begin
         bus1.req_valid = v; bus1.req_write = wr; bus1.req_addr = addr;
         bus1.req_wdata = wdata; bus1.req_size = size; bus1.req_unsigned = uns;
      end else begin
         bus0.req_valid = v; bus0.req_write = wr; bus0.req_addr = addr;
         bus0.req_wdata = wdata; bus0.req_size = size; bus0.req_unsigned = uns;
      end
   endtask

   task automatic set_rr(input bit w, input bit v);
      if (w) bus1.rsp_ready = v;
      else   bus0.rsp_ready = v;
   endtask

   task automatic model_init();
      for (int i = 0; i < DEPTH; i++) begin
         model1[i] = 32'(i);
         model0[i] = 32'(i);
      end
   endtask

   // Reference behaviour: byte-addressed memory over a word array, plain arithmetic
   task automatic model_access(input bit w, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [1:0] size, input bit uns,
                               output logic [31:0] rd, output logic err);
      int unsigned idx, off;
      logic [31:0] word, fmask;
      idx = addr / 4;
      off = addr % 4;
      err = (size == 2'd3) || (size == 2'd1 && (off % 2) == 1) ||
            (size == 2'd2 && off != 0) || (idx >= DEPTH);
      rd  = 32'd0;
      if (err) return;
      word = w ? model1[idx] : model0[idx];
      if (wr) begin
         fmask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
         word  = (word & ~(fmask << (8 * off))) | ((wdata & fmask) << (8 * off));
         if (w) model1[idx] = word;
         else   model0[idx] = word;
      end else if (size == 2'd0) begin
         rd = (word >> (8 * off)) & 32'hFF;
         if (!uns && rd >= 32'd128) rd = rd | 32'hFFFF_FF00;
      end else if (size == 2'd1) begin
         rd = (word >> (8 * off)) & 32'hFFFF;
         if (!uns && rd >= 32'd32768) rd = rd | 32'hFFFF_0000;
      end else begin
         rd = word;
      end
   endtask

   // One complete transaction with latency, stall-stability and handshake checks
   task automatic txn(input bit w, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] size, input bit uns, input int stall, input string name);
      logic [31:0] exp_rd;
      logic        exp_err;
      int          lat, exp_lat;
      bit          seen;
      exp_lat = w ? 2 : 1;
      model_access(w, wr, addr, wdata, size, uns, exp_rd, exp_err);
      @(negedge clk);
      total++;
      if (get_rq(w) !== 1'b1) begin
         bad++;
         $display("FAIL %s idle_ready got=%b want=1", name, get_rq(w));
      end
      set_req(w, 1'b1, wr, addr, wdata, size, uns);
      set_rr(w, 1'b0);
      @(posedge clk); #1;
      set_req(w, 1'b0, 1'($urandom), $urandom, $urandom, 2'($urandom), 1'($urandom));
      set_rr(w, 1'($urandom));
      seen = 0;
      lat  = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         lat++;
         if (get_rv(w) === 1'b1) begin
            seen = 1;
         end else begin
            total++;
            if (get_rq(w) !== 1'b0) begin
               bad++;
               $display("FAIL %s busy_ready got=%b want=0", name, get_rq(w));
            end
         end
      end
      total++;
      if (!seen || lat != exp_lat) begin
         bad++;
         $display("FAIL %s latency got=%0d seen=%0b want=%0d", name, lat, seen, exp_lat);
      end
      if (!seen) begin
         set_rr(w, 1'b0);
         return;
      end
      set_rr(w, stall == 0);
      total++;
      if (get_rd(w) !== exp_rd) begin
         bad++;
         $display("FAIL %s rdata got=%h want=%h", name, get_rd(w), exp_rd);
      end
      total++;
      if (get_er(w) !== exp_err) begin
         bad++;
         $display("FAIL %s err got=%b want=%b", name, get_er(w), exp_err);
      end
      for (int k = 0; k < stall; k++) begin
         @(negedge clk);
         total++;
         if ({get_rv(w), get_rq(w), get_rd(w), get_er(w)} !== {1'b1, 1'b0, exp_rd, exp_err}) begin
            bad++;
            $display("FAIL %s stall%0d got v=%b r=%b d=%h e=%b want v=1 r=0 d=%h e=%b",
                     name, k, get_rv(w), get_rq(w), get_rd(w), get_er(w), exp_rd, exp_err);
         end
      end
      set_rr(w, 1'b1);
      @(posedge clk); #1;
      set_rr(w, 1'b0);
      @(negedge clk);
      total++;
      if ({get_rv(w), get_rq(w)} !== 2'b01) begin
         bad++;
         $display("FAIL %s post_handshake got v=%b r=%b want v=0 r=1", name, get_rv(w), get_rq(w));
      end
   endtask

   task automatic test_reset();
      for (int w = 0; w < 2; w++) begin
         total++;
         if ({get_rq(1'(w)), get_rv(1'(w)), get_rd(1'(w)), get_er(1'(w))} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs dut%0d got r=%b v=%b d=%h e=%b want r=1 v=0 d=0 e=0",
                     w, get_rq(1'(w)), get_rv(1'(w)), get_rd(1'(w)), get_er(1'(w)));
         end
      end
   endtask

   task automatic test_load_word();
      txn(1, 0, 32'h10, 32'h0, 2'd2, 0, 0, "lw_0x10");
   endtask

   task automatic test_store_load();
      txn(1, 1, 32'h20, 32'hDEAD_BEEF, 2'd2, 0, 0, "sw_0x20");
      txn(1, 0, 32'h23, 32'h0, 2'd0, 0, 0, "lb_0x23");
      txn(1, 0, 32'h23, 32'h0, 2'd0, 1, 0, "lbu_0x23");
      txn(1, 0, 32'h20, 32'h0, 2'd1, 0, 0, "lh_0x20");
      txn(1, 0, 32'h22, 32'h0, 2'd1, 1, 1, "lhu_0x22");
   endtask

   task automatic test_byte_store();
      txn(1, 1, 32'h31, 32'hFFFF_FF5A, 2'd0, 0, 0, "sb_0x31");
      txn(1, 0, 32'h30, 32'h0, 2'd2, 0, 0, "lw_0x30");
      txn(1, 1, 32'h36, 32'h1234_8001, 2'd1, 0, 0, "sh_0x36");
      txn(1, 0, 32'h34, 32'h0, 2'd2, 0, 0, "lw_0x34");
   endtask

   task automatic test_errors();
      txn(1, 0, 32'h21, 32'h0, 2'd1, 0, 0, "err_lh_0x21");
      txn(1, 0, 32'h22, 32'h0, 2'd2, 0, 0, "err_lw_0x22");
      txn(1, 0, 32'h24, 32'h0, 2'd3, 0, 0, "err_size3");
      txn(1, 0, DEPTH * 4, 32'h0, 2'd2, 0, 0, "err_lw_range");
      txn(1, 1, 32'h22, 32'h1111_1111, 2'd2, 0, 0, "err_sw_0x22");
      txn(1, 1, 32'h27, 32'h2222_2222, 2'd1, 0, 0, "err_sh_0x27");
      txn(1, 1, 32'h24, 32'h3333_3333, 2'd3, 0, 0, "err_ss3");
      txn(1, 1, DEPTH * 4 + 8, 32'h4444_4444, 2'd0, 0, 0, "err_sb_range");
      txn(1, 0, 32'h20, 32'h0, 2'd2, 0, 0, "lw_0x20_after_err");
      txn(1, 0, 32'h24, 32'h0, 2'd2, 0, 0, "lw_0x24_after_err");
   endtask

   task automatic test_stall();
      txn(1, 1, 32'h40, 32'h1, 2'd2, 0, 5, "sw_stall_0x40");
      txn(1, 0, 32'h40, 32'h0, 2'd2, 0, 3, "lw_0x40");
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      set_req(1, 1'b1, 1'b1, 32'h8, 32'h77, 2'd2, 1'b0);
      @(posedge clk); #1;
      set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
      set_rr(1, 1'b1);
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (get_rv(1) !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_valid cyc%0d got=%b want=0", i, get_rv(1));
         end
      end
      reset_n = 1'b1;
      set_rr(1, 1'b0);
      model_init();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if ({get_rv(1), get_rq(1)} !== 2'b01) begin
            bad++;
            $display("FAIL post_reset_idle cyc%0d got v=%b r=%b want v=0 r=1", i, get_rv(1), get_rq(1));
         end
      end
      txn(1, 0, 32'h8, 32'h0, 2'd2, 0, 0, "lw_0x8_after_reset");
      txn(0, 0, 32'h40, 32'h0, 2'd2, 0, 0, "dut0_lw_0x40_after_reset");
   endtask

   task automatic test_wait0();
      txn(0, 0, 32'h10, 32'h0, 2'd2, 0, 0, "w0_lw_0x10");
      txn(0, 1, 32'h20, 32'hCAFE_F00D, 2'd2, 0, 2, "w0_sw_0x20");
      txn(0, 0, 32'h22, 32'h0, 2'd1, 0, 0, "w0_lh_0x22");
      txn(0, 0, 32'h21, 32'h0, 2'd0, 1, 0, "w0_lbu_0x21");
      txn(0, 0, 32'h23, 32'h0, 2'd2, 0, 0, "w0_err_lw_0x23");
   endtask

   task automatic test_random();
      for (int n = 0; n < 120; n++) begin
         logic [31:0] addr;
         addr = 32'($urandom_range(0, DEPTH * 4 + 15));
         if ($urandom_range(0, 9) == 0) addr = $urandom;
         txn(1'(n % 2), 1'($urandom), addr, $urandom, 2'($urandom_range(0, 3)), 1'($urandom),
             int'($urandom_range(0, 2)), $sformatf("rand%0d", n));
      end
   endtask

   initial begin
      reset_n = 1'b0;
      set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
      set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
      set_rr(1, 1'b0);
      set_rr(0, 1'b0);
      model_init();
      repeat (2) @(posedge clk);
      @(negedge clk);
      test_reset();
      reset_n = 1'b1;
      test_load_word();
      test_store_load();
      test_byte_store();
      test_errors();
      test_stall();
      test_reset_mid();
      test_wait0();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
